ysyx_exec_seq: RTL

- Multi-cycle sequencer for the single-issue RV32 core.
- Drives the fetch/decode/execute/memory/writeback sequence around the instruction decoder.
- Handshakes with the instruction fetch port and the load/store port.
- Gates register-file and PC writes to exactly one commit per instruction, and halts the core on ebreak.

---
 rtl/ysyx_exec_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_exec_seq.sv
// ---------------------------------------------------------------------------
// ysyx_exec_seq
//
// Multi-cycle sequencer for the single-issue RV32 core. Walks each instruction
// through fetch, decode/execute, optional memory access and writeback. It
// handshakes with the instruction fetch port and the load/store port. It
// allows exactly one register-file/PC commit per instruction and halts the
// core on ebreak.
//
// Optional feature: define YSYX_EXEC_SEQ_WDOG_EN to enable the wait-state
// watchdog. With it, any handshake wait lasting WDOG_CYCLES cycles halts the
// core with wdog_err=1. Without it, waits last indefinitely and wdog_err is
// tied to 0.
//
// Parameters:
//   CNT_W        width of the retired-instruction counter
//   WDOG_CYCLES  wait-state timeout in cycles (watchdog build only)
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   ifu_req_valid/ifu_req_ready      fetch request handshake at current PC
//   ifu_rsp_valid                    fetched instruction available
//   ir_we                            latch fetched word into the IR
//   dec_rf_wr_en, dec_dm_rd_sel,
//   dec_dm_wr_sel, dec_ebreak        decoder outputs, stable while in EXEC..WB
//   lsu_req_valid/lsu_req_ready      data memory request handshake
//   lsu_req_wen                      1 = store, 0 = load
//   lsu_rsp_valid                    load data valid / store complete
//   rf_we, pc_we                     commit strobes (WB only)
//   halt, wdog_err                   sticky halt status, halted by timeout
//   state                            current FSM state for trace
//   inst_cnt                         retired-instruction count
// ---------------------------------------------------------------------------
module ysyx_exec_seq #(
   parameter int CNT_W       = 32,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             ifu_req_valid,
   input  logic             ifu_req_ready,
   input  logic             ifu_rsp_valid,
   output logic             ir_we,
   input  logic             dec_rf_wr_en,
   input  logic [2:0]       dec_dm_rd_sel,
   input  logic [1:0]       dec_dm_wr_sel,
   input  logic             dec_ebreak,
   output logic             lsu_req_valid,
   output logic             lsu_req_wen,
   input  logic             lsu_req_ready,
   input  logic             lsu_rsp_valid,
   output logic             rf_we,
   output logic             pc_we,
   output logic             halt,
   output logic             wdog_err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] inst_cnt
);

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      FWAIT = 3'd1,
      EXEC  = 3'd2,
      MREQ  = 3'd3,
      MWAIT = 3'd4,
      WB    = 3'd5,
      HALT  = 3'd6
   } state_t;

   state_t state_q;
   state_t state_base;
   state_t state_d;
   logic   is_store;
   logic   is_load;
   logic   retire;

   assign is_store = (dec_dm_wr_sel != 2'd0);
   assign is_load  = (dec_dm_rd_sel != 3'd0);

   // An instruction retires in WB. An ebreak retires on its way into HALT,
   // which is why inst_cnt counts it even though it never reaches WB.
   assign retire = (state_q == WB) || ((state_q == EXEC) && dec_ebreak);

   // Normal sequencing. Each wait state advances only on its own handshake,
   // so responses arriving in any other state are ignored. The unused
   // encoding 7 falls back to FETCH.
   always_comb begin
      state_base = state_q;
      case (state_q)
         FETCH: if (ifu_req_ready) state_base = FWAIT;
         FWAIT: if (ifu_rsp_valid) state_base = EXEC;
         EXEC: begin
            if (dec_ebreak)                state_base = HALT;
            else if (is_store || is_load)  state_base = MREQ;
            else                           state_base = WB;
         end
         MREQ:  if (lsu_req_ready) state_base = MWAIT;
         MWAIT: if (lsu_rsp_valid) state_base = WB;
         WB:    state_base = FETCH;
         HALT:  state_base = HALT;
         default: state_base = FETCH;
      endcase
   end

`ifdef YSYX_EXEC_SEQ_WDOG_EN
   localparam int                WCNT_W    = $clog2(WDOG_CYCLES) + 1;
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WDOG_CYCLES - 1);

   logic [WCNT_W-1:0] wait_cnt_q;
   logic              wait_state;
   logic              timeout;
   logic              wdog_err_q;

   // The watchdog fires on the last allowed wait cycle only if the FSM is
   // not advancing, so a handshake landing on that same cycle still wins.
   assign wait_state = state_q inside {FETCH, FWAIT, MREQ, MWAIT};
   assign timeout    = wait_state && (state_base == state_q) && (wait_cnt_q == WAIT_LAST);
   assign state_d    = timeout ? HALT : state_base;
   assign wdog_err   = wdog_err_q;

   // Wait counter restarts on every state change, so it measures the time
   // spent in the current wait state. The error flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         if (state_d != state_q)
            wait_cnt_q <= '0;
         else if (wait_state)
            wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
         if (timeout)
            wdog_err_q <= 1'b1;
      end
   end
`else
   logic unused_wdog_cycles;

   assign unused_wdog_cycles = (WDOG_CYCLES > 0);
   assign state_d            = state_base;
   assign wdog_err           = 1'b0;
`endif

   // State register and retired-instruction counter. Reset drops any
   // outstanding request by simply returning to FETCH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= FETCH;
         inst_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (retire)
            inst_cnt <= inst_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Output decode from the current state. ir_we tracks the fetch response
   // so the IR captures the word in the single cycle it is presented. rf_we
   // is additionally qualified by the decoder. Strobes and valids are held
   // low while reset is asserted.
   always_comb begin
      ifu_req_valid = 1'b0;
      ir_we         = 1'b0;
      lsu_req_valid = 1'b0;
      lsu_req_wen   = 1'b0;
      pc_we         = 1'b0;
      rf_we         = 1'b0;
      if (rst_n) begin
         case (state_q)
            FETCH: ifu_req_valid = 1'b1;
            FWAIT: ir_we = ifu_rsp_valid;
            MREQ: begin
               lsu_req_valid = 1'b1;
               lsu_req_wen   = is_store;
            end
            WB: begin
               pc_we = 1'b1;
               rf_we = dec_rf_wr_en;
            end
            default: ;
         endcase
      end
   end

   assign halt  = (state_q == HALT);
   assign state = state_q;

endmodule
